rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Arbiter for the single write port of the 32×32 register file. Shares that port between two requesters: the pipeline writeback stage (fixed high priority) and a debug/loader port (valid/ready handshake). Guarantees the debug port forward progress by stalling writeback after a bounded wait. Drives the register file's `RF_WRITE`/`Rdst`/`RY` inputs from registered outputs.

## Interface
- `MAX_WAIT`, default 8: cycles a debug request may wait before a forced grant. Legal range 1..255.
- `ZERO_REG_PROTECT`, default 1: when 1, writes addressed to R0 are accepted but never reach the register file.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `PIPE_WRITE` in 1: writeback requests a write this cycle.
- `PIPE_Rdst` in 5: writeback destination address.
- `PIPE_RY` in 32: writeback data.
- `PIPE_STALL` out 1: registered. While high, writeback is not accepted and must hold `PIPE_WRITE`/`PIPE_Rdst`/`PIPE_RY` stable.
- `DBG_VALID` in 1: debug write request.
- `DBG_Rdst` in 5: debug destination address.
- `DBG_DATA` in 32: debug data.
- `DBG_READY` out 1: combinational grant. A transfer completes on a cycle where `DBG_VALID` and `DBG_READY` are both high.
- `RF_WRITE` out 1: registered write enable to the register file.
- `Rdst` out 5: registered write address.
- `RY` out 32: registered write data.

## Operation
- State machine, 2 states:
  - NORMAL: the pipeline has priority.
  - FORCE: the debug port has priority for exactly one cycle.
- Pipeline occupancy:
  - `pipe_req` = `PIPE_WRITE` & !(`ZERO_REG_PROTECT` & `PIPE_Rdst`==0).
  - A protected R0 pipeline write is accepted silently and does not occupy the port.
- Grant in NORMAL:
  - `DBG_READY` = `DBG_VALID` & !`pipe_req`.
  - The pipeline write, if `pipe_req`, is issued.
- Grant in FORCE:
  - `DBG_READY` = `DBG_VALID`. The debug write is issued.
  - `PIPE_STALL`=1. Pipeline input is ignored.
- Issue:
  - The selected request's address and data are loaded into `Rdst`/`RY`.
  - `RF_WRITE` is set to 1 unless the address is 0 and `ZERO_REG_PROTECT`=1.
  - With no issue, `RF_WRITE`=0 and `Rdst`/`RY` hold their previous values.
- Starvation counter `wait_cnt`, 8 bits:
  - Cleared when `DBG_VALID`=0 or on a debug handshake.
  - Otherwise increments, saturating at `MAX_WAIT`.
- Transitions:
  - NORMAL→FORCE when `DBG_VALID` & !`DBG_READY` & `wait_cnt`==`MAX_WAIT`-1.
  - FORCE→NORMAL unconditionally after one cycle.
  - If `DBG_VALID` drops while in FORCE (protocol violation), there is no issue that cycle, and the state still returns to NORMAL.
- Debug protocol: `DBG_VALID` must remain high with a stable payload until `DBG_READY`. The arbiter does not buffer debug requests.
- Both ports writing the same address in one cycle: there is no merge. The pipeline write is issued and the debug request keeps waiting. With `MAX_WAIT`=N, it is granted no later than N+1 cycles after `DBG_VALID` rises.

## Timing
- Latency: a request accepted in cycle t appears on `RF_WRITE`/`Rdst`/`RY` in cycle t+1, and is written into the register file at the end of t+1.
- `PIPE_STALL` is high exactly in FORCE cycles. It is never high in two consecutive cycles.
- Reset values: `RF_WRITE`=0, `Rdst`=0, `RY`=0, `PIPE_STALL`=0, state NORMAL, `wait_cnt`=0.
- While `reset`=1, `DBG_READY` is 0 and no write is issued.
- Reset asserted in FORCE: the next cycle is NORMAL with `PIPE_STALL`=0, and any pending debug request restarts its wait from 0.

## Structure
- Shared package `rf_arb_pkg` holds:
  - the state typedef (NORMAL, FORCE);
  - `RF_ADDR_W`=5 and `RF_DATA_W`=32;
  - the R0 address constant.
- Single flat module, no sub-modules. The saturating counter is small enough to stay inline.

## Test plan
- **Reset:** hold `reset` 3 cycles with `PIPE_WRITE`=1 and `DBG_VALID`=1. Required: all outputs 0 and `DBG_READY`=0. After release, the pipeline write issues on the next cycle.
- **Pipeline only:** `PIPE_WRITE`, `PIPE_Rdst`=5, `PIPE_RY`=0xDEADBEEF at cycle t. Required: `RF_WRITE`=1, `Rdst`=5, `RY`=0xDEADBEEF at t+1, and `PIPE_STALL` stays 0.
- **Debug in idle:** `DBG_VALID`, `DBG_Rdst`=31, `DBG_DATA`=0x12345678 with the pipeline idle. Required: `DBG_READY`=1 the same cycle, and the write appears on the register file port the next cycle.
- **Starvation:** `MAX_WAIT`=4, `PIPE_WRITE` held high continuously to `PIPE_Rdst`=3, `DBG_VALID` high from cycle 0 to `DBG_Rdst`=7. Required:
  - `DBG_READY`=0 in cycles 0–3;
  - FORCE with `PIPE_STALL`=1 and `DBG_READY`=1 in cycle 4;
  - `Rdst`=7 in cycle 5, `Rdst`=3 in cycle 6.
- **R0 protection:** with `ZERO_REG_PROTECT`=1, `PIPE_WRITE` to `PIPE_Rdst`=0 and `DBG_VALID` to `DBG_Rdst`=9 in the same cycle. Required: `DBG_READY`=1 that cycle, then `RF_WRITE`=1 with `Rdst`=9. A debug write to R0 completes the handshake with `RF_WRITE`=0.
- **Mid-operation reset and protocol violation:**
  - Reset asserted in a FORCE cycle. Required: `PIPE_STALL`=0 the next cycle and `wait_cnt` restarts from 0.
  - `DBG_VALID` dropped in FORCE. Required: `RF_WRITE`=0 the next cycle and return to NORMAL.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Address/data widths match the 32x32 register file.
package rf_arb_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] R0_ADDR = '0;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback, debug and register-file-port signals around the arbiter.
// The master side drives requests; the slave side is the arbiter itself.
interface rf_write_arbiter_if;
    import rf_arb_pkg::*;

    logic                 PIPE_WRITE;
    logic [RF_ADDR_W-1:0] PIPE_Rdst;
    logic [RF_DATA_W-1:0] PIPE_RY;
    logic                 PIPE_STALL;

    logic                 DBG_VALID;
    logic [RF_ADDR_W-1:0] DBG_Rdst;
    logic [RF_DATA_W-1:0] DBG_DATA;
    logic                 DBG_READY;

    logic                 RF_WRITE;
    logic [RF_ADDR_W-1:0] Rdst;
    logic [RF_DATA_W-1:0] RY;

    modport master (
        output PIPE_WRITE, PIPE_Rdst, PIPE_RY,
        output DBG_VALID, DBG_Rdst, DBG_DATA,
        input  PIPE_STALL, DBG_READY,
        input  RF_WRITE, Rdst, RY
    );

    modport slave (
        input  PIPE_WRITE, PIPE_Rdst, PIPE_RY,
        input  DBG_VALID, DBG_Rdst, DBG_DATA,
        output PIPE_STALL, DBG_READY,
        output RF_WRITE, Rdst, RY
    );

endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between writeback (priority) and a
// debug/loader port, forcing one debug grant after MAX_WAIT blocked cycles.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int MAX_WAIT         = 8,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [7:0] WAIT_SAT  = 8'(MAX_WAIT);

    arb_state_e           state;
    arb_state_e           state_next;
    logic [7:0]           wait_cnt;
    logic [7:0]           wait_cnt_next;

    logic                 pipe_req;
    logic                 dbg_ready;
    logic                 issue;
    logic [RF_ADDR_W-1:0] issue_rdst;
    logic [RF_DATA_W-1:0] issue_ry;

    logic                 vld_p1;
    logic [RF_ADDR_W-1:0] rdst_p1;
    logic [RF_DATA_W-1:0] ry_p1;

    function automatic logic is_protected(input logic [RF_ADDR_W-1:0] addr);
        return ZERO_REG_PROTECT && (addr == R0_ADDR);
    endfunction

    always_comb begin
        state_next    = NORMAL;
        wait_cnt_next = '0;
        dbg_ready     = 1'b0;
        issue         = 1'b0;
        issue_rdst    = bus.PIPE_Rdst;
        issue_ry      = bus.PIPE_RY;
        pipe_req      = bus.PIPE_WRITE && !is_protected(bus.PIPE_Rdst);

        if (!reset) begin
            // In FORCE the pipeline is stalled, so its request is ignored outright.
            if (state == FORCE) begin
                dbg_ready = bus.DBG_VALID;
            end else begin
                dbg_ready = bus.DBG_VALID && !pipe_req;
            end

            if (state == NORMAL && pipe_req) begin
                issue = 1'b1;
            end else if (dbg_ready) begin
                issue      = 1'b1;
                issue_rdst = bus.DBG_Rdst;
                issue_ry   = bus.DBG_DATA;
            end

            if (!bus.DBG_VALID || dbg_ready) begin
                wait_cnt_next = '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt_next = wait_cnt + 8'd1;
            end else begin
                wait_cnt_next = wait_cnt;
            end

            if (state == NORMAL && bus.DBG_VALID && !dbg_ready && wait_cnt == WAIT_LAST) begin
                state_next = FORCE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Stage p1: registered register-file write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            rdst_p1 <= '0;
            ry_p1   <= '0;
        end else begin
            vld_p1 <= issue && !is_protected(issue_rdst);
            if (issue) begin
                rdst_p1 <= issue_rdst;
                ry_p1   <= issue_ry;
            end
        end
    end

    assign bus.DBG_READY  = dbg_ready;
    assign bus.PIPE_STALL = (state == FORCE);
    assign bus.RF_WRITE   = vld_p1;
    assign bus.Rdst       = rdst_p1;
    assign bus.RY         = ry_p1;

endmodule
